branch_resolve_unit: RTL and testbench

Pipelined, parametrised branch resolution unit for the pipelined Otter core. It accepts one conditional branch per cycle from the execute stage and produces registered outputs two stages later:
- the taken decision and the branch target;
- the redirect PC and a misprediction flag for the fetch and hazard logic.

A valid/ready handshake provides back-pressure, and a flush input kills in-flight branches.

---
 rtl/branch_resolve_unit.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Two-stage branch resolution pipeline for the Otter core. S1 registers
//   the operand compares (eq, signed lt, unsigned lt) together with the
//   branch context. S2 decodes funct3 into the taken decision, forms the
//   target and the redirect PC, and flags mispredictions. A valid/ready
//   handshake on both sides provides back-pressure. A flush kills every
//   in-flight branch.
//
// Optional feature macro: BRANCH_RESOLVE_STATS_EN
//   When defined, it adds the stat_branches and stat_mispredicts counters.
//   They count completed legal branches and completed mispredicted branches.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   in_valid/ready    input handshake (in_ready: combinational)
//   in_funct3         B-type funct3
//   in_rs1, in_rs2    source operands
//   in_pc, in_imm     branch PC and sign-extended B-immediate
//   in_pred_taken     fetch-stage prediction
//   flush             discard all in-flight branches
//   out_valid/ready   output handshake
//   out_taken         branch condition true
//   out_target        pc + imm (mod 2^XLEN)
//   out_redirect_pc   taken ? target : pc + 4 (mod 2^XLEN)
//   out_mispredict    taken ^ predicted
//   out_illegal       funct3 is 010 or 011
//   stat_branches     completed legal branches (stats build only)
//   stat_mispredicts  completed mispredicted branches (stats build only)
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int STATS_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_pred_taken,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_taken,
  output logic [XLEN-1:0]    out_target,
  output logic [XLEN-1:0]    out_redirect_pc,
  output logic               out_mispredict,
  output logic               out_illegal
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [STATS_W-1:0] stat_branches,
  output logic [STATS_W-1:0] stat_mispredicts
`endif
);

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  function automatic logic resolve_taken(input logic [2:0] f3, input logic eq,
                                         input logic lt, input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = eq;
      3'b001:  t = !eq;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   accept;
  logic                   s2_adv;

  logic                   vld_p1;
  logic                   eq_p1;
  logic                   lt_p1;
  logic                   ltu_p1;
  logic [2:0]             funct3_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [XLEN-1:0]        imm_p1;
  logic                   pred_p1;

  logic                   illegal_p1;
  logic                   taken_p1;
  logic [XLEN-1:0]        target_p1;
  logic [XLEN-1:0]        redirect_p1;

  assign rs1_s    = in_rs1;
  assign rs2_s    = in_rs2;
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = (!vld_p1 || s2_adv) && !flush;
  assign accept   = in_valid && in_ready;

  // ---- S1: operand compares ----
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (s2_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      eq_p1     <= (in_rs1 == in_rs2);
      lt_p1     <= (rs1_s < rs2_s);
      ltu_p1    <= (in_rs1 < in_rs2);
      funct3_p1 <= in_funct3;
      pc_p1     <= in_pc;
      imm_p1    <= in_imm;
      pred_p1   <= in_pred_taken;
    end
  end

  // ---- S2: resolve (decode, target adder, redirect mux) ----
  assign illegal_p1  = is_illegal(funct3_p1);
  assign taken_p1    = !illegal_p1 && resolve_taken(funct3_p1, eq_p1, lt_p1, ltu_p1);
  assign target_p1   = pc_p1 + imm_p1;
  assign redirect_p1 = taken_p1 ? target_p1 : (pc_p1 + XLEN'(4));

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_redirect_pc <= '0;
      out_mispredict  <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_taken       <= taken_p1;
        out_target      <= target_p1;
        out_redirect_pc <= redirect_p1;
        out_mispredict  <= taken_p1 ^ pred_p1;
        out_illegal     <= illegal_p1;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // ---- statistics on completed output transfers ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (out_valid && out_ready && !out_illegal) begin
      stat_branches <= stat_branches + STATS_W'(1);
      if (out_mispredict) begin
        stat_mispredicts <= stat_mispredicts + STATS_W'(1);
      end
    end
  end
`else
  if (STATS_W < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int XLEN    = 32;
  localparam int STATS_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_funct3;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic              in_pred_taken;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic [XLEN-1:0]   out_target;
  logic [XLEN-1:0]   out_redirect_pc;
  logic              out_mispredict;
  logic              out_illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [STATS_W-1:0] stat_branches;
  logic [STATS_W-1:0] stat_mispredicts;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .STATS_W(STATS_W)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_funct3       (in_funct3),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_pred_taken   (in_pred_taken),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_taken       (out_taken),
    .out_target      (out_target),
    .out_redirect_pc (out_redirect_pc),
    .out_mispredict  (out_mispredict),
    .out_illegal     (out_illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect;
    logic        mis;
    logic        ill;
  } vec_t;

  vec_t vecs [11];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                              input logic taken, input logic [31:0] target, input logic [31:0] redirect,
                              input logic mis, input logic ill);
    vec_t v;
    v.funct3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pred = pred;
    v.taken = taken; v.target = target; v.redirect = redirect; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    in_funct3     = v.funct3;
    in_rs1        = v.rs1;
    in_rs2        = v.rs2;
    in_pc         = v.pc;
    in_imm        = v.imm;
    in_pred_taken = v.pred;
    in_valid      = 1'b1;
  endtask

  task automatic drive_stream(input int k);
    in_funct3     = 3'b000;
    in_rs1        = 32'h0;
    in_rs2        = 32'h0;
    in_pc         = 32'h1000 + 32'(16 * k);
    in_imm        = 32'h0;
    in_pred_taken = 1'b0;
    in_valid      = 1'b1;
  endtask

  // Present one vector with out_ready=1 and check 2-cycle latency and all result fields.
  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive_vec(v);
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d latency out_valid", i), 32'(out_valid), 32'd0);
    @(posedge CLK); #1;
    chk($sformatf("v%0d out_valid", i),       32'(out_valid),      32'd1);
    chk($sformatf("v%0d out_taken", i),       32'(out_taken),      32'(v.taken));
    chk($sformatf("v%0d out_target", i),      out_target,          v.target);
    chk($sformatf("v%0d out_redirect_pc", i), out_redirect_pc,     v.redirect);
    chk($sformatf("v%0d out_mispredict", i),  32'(out_mispredict), 32'(v.mis));
    chk($sformatf("v%0d out_illegal", i),     32'(out_illegal),    32'(v.ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  recv;
    logic acc;

    //            f3      rs1           rs2           pc            imm           pr  tk  target        redirect      mis ill
    vecs[0]  = mk(3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00001000, 32'h00000020, 0,  1,  32'h00001020, 32'h00001020, 1,  0);
    vecs[1]  = mk(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00001000, 32'h00000020, 0,  0,  32'h00001020, 32'h00001004, 0,  0);
    vecs[2]  = mk(3'b000, 32'h00001234, 32'h00001234, 32'hFFFFFFF8, 32'h00000010, 1,  1,  32'h00000008, 32'h00000008, 0,  0);
    vecs[3]  = mk(3'b001, 32'h00000005, 32'h00000005, 32'h00000100, 32'h00000040, 1,  0,  32'h00000140, 32'h00000104, 1,  0);
    vecs[4]  = mk(3'b101, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000200, 32'hFFFFFFF0, 0,  0,  32'h000001F0, 32'h00000204, 0,  0);
    vecs[5]  = mk(3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000300, 32'h00000008, 0,  1,  32'h00000308, 32'h00000308, 1,  0);
    vecs[6]  = mk(3'b010, 32'h00000000, 32'h00000000, 32'h00000400, 32'h00000010, 1,  0,  32'h00000410, 32'h00000404, 1,  1);
    vecs[7]  = mk(3'b011, 32'h00000000, 32'h00000000, 32'h00000500, 32'h00000004, 0,  0,  32'h00000504, 32'h00000504, 0,  1);
    vecs[8]  = mk(3'b001, 32'h00000003, 32'h00000007, 32'hFFFFFFFC, 32'h00000000, 1,  1,  32'hFFFFFFFC, 32'hFFFFFFFC, 0,  0);
    vecs[9]  = mk(3'b000, 32'h00000001, 32'h00000002, 32'hFFFFFFFC, 32'h00000008, 0,  0,  32'h00000004, 32'h00000000, 0,  0);
    vecs[10] = mk(3'b100, 32'h00000005, 32'h00000005, 32'h00000600, 32'h00000080, 0,  0,  32'h00000680, 32'h00000604, 0,  0);

    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset out_valid",       32'(out_valid),      32'd0);
    chk("reset out_taken",       32'(out_taken),      32'd0);
    chk("reset out_target",      out_target,          32'd0);
    chk("reset out_redirect_pc", out_redirect_pc,     32'd0);
    chk("reset out_mispredict",  32'(out_mispredict), 32'd0);
    chk("reset out_illegal",     32'(out_illegal),    32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("reset stat_branches",    stat_branches,    32'd0);
    chk("reset stat_mispredicts", stat_mispredicts, 32'd0);
`endif

    for (int i = 0; i < 11; i++) apply_vec(i);

    // Back-pressure: drain, then stall with out_ready=0 and offer 4 branches.
    in_valid = 1'b0;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (sent < 4) drive_stream(sent); else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      @(posedge CLK); #1;
      if (acc) sent++;
      if (c >= 1) begin
        chk($sformatf("stall c%0d out_valid", c),  32'(out_valid), 32'd1);
        chk($sformatf("stall c%0d out_target", c), out_target,     32'h1000);
      end
    end
    chk("stall accepted count", 32'(sent), 32'd2);
    drive_stream(sent);
    #1;
    chk("stall in_ready", 32'(in_ready), 32'd0);

    out_ready = 1'b1;
    recv = 0;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      if (sent < 4) drive_stream(sent); else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("drain r%0d out_target", recv), out_target, 32'h1000 + 32'(16 * recv));
        recv++;
      end
      @(posedge CLK); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("drain received count", 32'(recv), 32'd4);
    chk("drain sent count",     32'(sent), 32'd4);
    chk("drain no duplicate",   32'(out_valid), 32'd0);

    // Reset mid-stream: taken branch in S2, another in flight.
    apply_vec(0);
    out_ready = 1'b0;
    drive_vec(vecs[5]);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    in_valid = 1'b0;
    chk("midrst out_valid",       32'(out_valid),      32'd0);
    chk("midrst out_taken",       32'(out_taken),      32'd0);
    chk("midrst out_target",      out_target,          32'd0);
    chk("midrst out_redirect_pc", out_redirect_pc,     32'd0);
    chk("midrst out_mispredict",  32'(out_mispredict), 32'd0);
    chk("midrst out_illegal",     32'(out_illegal),    32'd0);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("midrst s1 discarded", 32'(out_valid), 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("midrst stat_branches", stat_branches, 32'd0);
`endif

    // Three legal (one mispredicted) and one illegal completion.
    apply_vec(2);
    apply_vec(3);
    apply_vec(9);
    apply_vec(6);
    in_valid = 1'b0;
    @(posedge CLK); #1;
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stats stat_branches",    stat_branches,    32'd3);
    chk("stats stat_mispredicts", stat_mispredicts, 32'd1);
`endif

    // Flush with both stages full and a new branch offered.
    out_ready = 1'b0;
    drive_vec(vecs[0]);
    #1;
    chk("flush fill A in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    drive_vec(vecs[1]);
    #1;
    chk("flush fill B in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    drive_vec(vecs[4]);
    flush = 1'b1;
    #1;
    chk("flush in_ready",        32'(in_ready),  32'd0);
    chk("flush pre out_valid",   32'(out_valid), 32'd1);
    @(posedge CLK); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush post out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk($sformatf("flush c%0d nothing emerges", c), 32'(out_valid), 32'd0);
    end
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("flush stat_branches",    stat_branches,    32'd3);
    chk("flush stat_mispredicts", stat_mispredicts, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
